crcu_apb_master: RTL and testbench
==================================

// Module: crcu_apb_master
// PURPOSE
// - APB requester feeding the CRCU APB slave.
// - Converts a valid/ready command channel (config sequencer or test host) into single APB3 transfers:
//   SETUP -> ACCESS, wait-state support, PREADY timeout.
// - Returns read data and error status on a valid/ready response channel.
// - One transfer outstanding at a time; sits directly upstream of the CRCU register slave.
// PARAMETERS
// - ADDR_W       32  APB address width (PADDR, req_addr)
// - DATA_W       32  APB data width (PWDATA, PRDATA, req_wdata, rsp_rdata)
// - TIMEOUT_CYC  16  max ACCESS cycles without PREADY before abort; legal range 1..255
// PORTS
// - PCLK         in   1       sole clock, rising edge
// - PRESETN      in   1       async active-low reset; asserts asynchronously, deasserts synchronously to PCLK
// - req_valid    in   1       command present
// - req_ready    out  1       command accepted when req_valid&req_ready
// - req_write    in   1       1=write, 0=read
// - req_addr     in   ADDR_W  target address
// - req_wdata    in   DATA_W  write data (ignored for reads)
// - rsp_valid    out  1       response present; held until rsp_ready
// - rsp_ready    in   1       response consumed
// - rsp_rdata    out  DATA_W  read data; 0 for writes and aborted transfers
// - rsp_err      out  1       PSLVERR seen, or timeout
// - rsp_timeout  out  1       transfer aborted by timeout (implies rsp_err)
// - PSEL         out  1       APB select
// - PENABLE      out  1       APB enable
// - PWRITE       out  1       APB direction
// - PADDR        out  ADDR_W  APB address
// - PWDATA       out  DATA_W  APB write data; 0 during reads
// - PRDATA       in   DATA_W  APB read data
// - PREADY       in   1       slave ready
// - PSLVERR      in   1       slave error; sampled only when PREADY=1
// BEHAVIOUR
// - All outputs registered. Reset value of every output is 0, except req_ready=1 once in IDLE after reset.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
//   - IDLE: req_ready=1. On handshake, latch write/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
//   - SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, then go to ACCESS. Clear the timeout counter.
//   - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
//     - PREADY=1: capture PRDATA (reads only) and PSLVERR, drop PSEL/PENABLE next cycle, go to RESP.
//     - PREADY=0: increment counter. When counter reaches TIMEOUT_CYC, abort:
//       rsp_err=1, rsp_timeout=1, rsp_rdata=0, drop PSEL/PENABLE, go to RESP.
//   - RESP: rsp_valid=1, rsp_* stable until rsp_ready. On handshake go to IDLE and clear rsp_valid.
// - Latency: handshake at cycle N, SETUP N+1, ACCESS N+2.
//   - Zero-wait slave: rsp_valid at N+3.
//   - Each wait state adds 1 cycle.
// - No back-to-back APB: req_ready=0 from SETUP through RESP; minimum 4 cycles per transfer.
// - PSLVERR with PREADY=0 is ignored; a slave that never raises PREADY ends via timeout.
// - rsp_ready high with rsp_valid low has no effect.
// - Async reset mid-transfer: PSEL/PENABLE drop immediately; pending response discarded; FSM to IDLE.
// - Counter is 8 bits; saturates; never wraps.
// STRUCTURE
// - Package crcu_apb_pkg:
//   - typedef enum logic [1:0] apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}
//   - APB_ADDR_W / APB_DATA_W localparams
//   - CRCU_MEM_WORDS = 124
// - Sub-module crcu_apb_wdog: loadable 8-bit timeout counter (clear, enable, expired flag).
// - FSM and datapath registers stay in this module.
// TESTING
// - Write, zero-wait: req(write=1, addr=0x10, wdata=0xDEADBEEF); PREADY=1
//   -> PSEL N+1, PENABLE N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
// - Read with 3 wait states: addr=0x10, PRDATA=0xDEADBEEF, PREADY high on 4th ACCESS cycle
//   -> PADDR stable throughout, rsp_rdata=0xDEADBEEF at N+6.
// - Slave error: read addr=200, PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
// - Timeout: PREADY stuck 0, TIMEOUT_CYC=16 -> 16 ACCESS cycles, then PSEL=0,
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// - Backpressure plus reset: hold rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0.
//   Then assert PRESETN=0 during ACCESS of the next transfer -> PSEL/PENABLE=0 immediately, rsp_valid=0.

Source files
------------

// File: rtl/crcu_apb_pkg.sv
// Shared types and constants for the CRCU APB requester and its neighbours.
package crcu_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  localparam int APB_ADDR_W     = 32;
  localparam int APB_DATA_W     = 32;
  localparam int CRCU_MEM_WORDS = 124;

endpackage

// File: rtl/crcu_apb_master_if.sv
// APB3 bus between the CRCU requester (master) and the CRCU register slave.
interface crcu_apb_master_if
  import crcu_apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/crcu_apb_wdog.sv
// Loadable 8-bit saturating wait-state counter; flags the last permitted cycle.
module crcu_apb_wdog #(
  parameter int LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds completed wait cycles, so the current enabled cycle is number cnt+1
  assign expired = (cnt >= LAST);

endmodule

// File: rtl/crcu_apb_master.sv
// Valid/ready command channel to single APB3 transfers, with PREADY timeout and
// a valid/ready response channel. One transfer in flight at a time.
module crcu_apb_master
  import crcu_apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  crcu_apb_master_if.master apb
);

  apb_mst_state_e state_q, state_d;

  logic take_req;
  logic acc_done;
  logic acc_abort;
  logic wd_load;
  logic wd_en;
  logic wd_expired;

  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  crcu_apb_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk      (PCLK),
    .rst_n    (PRESETN),
    .load     (wd_load),
    .load_val (8'd0),
    .en       (wd_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_req  = 1'b0;
    acc_done  = 1'b0;
    acc_abort = 1'b0;
    wd_load   = 1'b0;
    wd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          take_req = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wd_load = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.PREADY) begin
          acc_done = 1'b1;
          state_d  = RESP;
        end else begin
          wd_en = 1'b1;
          if (wd_expired) begin
            acc_abort = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop; control flops follow the next state so they line up with it
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      if (take_req) begin
        pwrite_q <= req_write;
        paddr_q  <= req_addr;
        pwdata_q <= req_write ? req_wdata : '0;
      end
      if (acc_done) begin
        rsp_rdata   <= pwrite_q ? '0 : apb.PRDATA;
        rsp_err     <= apb.PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (acc_abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_crcu_apb_master.sv
// Directed bench for crcu_apb_master: latency, wait states, errors, timeout, reset.
module tb_crcu_apb_master;

  logic        PCLK;
  logic        PRESETN;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int errors = 0;
  int checks = 0;

  crcu_apb_master_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  crcu_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_psel_penable: got %b%b want 00", apb.PSEL, apb.PENABLE); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_flags: got %b%b%b want 000", rsp_valid, rsp_err, rsp_timeout); end
    checks++; if (apb.PADDR !== 32'h0 || apb.PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got %h %h %h want zeros", apb.PADDR, apb.PWDATA, rsp_rdata); end
    step();
    step();
    PRESETN = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write_zero_wait();
    apb.PREADY = 1'b1;
    apb.PSLVERR = 1'b0;
    apb.PRDATA = 32'h5555_AAAA;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    checks++; if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_setup: got psel=%b penable=%b want 1 0", apb.PSEL, apb.PENABLE); end
    checks++; if (apb.PWRITE !== 1'b1 || apb.PADDR !== 32'h10 || apb.PWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_setup_bus: got %b %h %h want 1 00000010 deadbeef", apb.PWRITE, apb.PADDR, apb.PWDATA); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_setup_req_ready: got %b want 0", req_ready); end
    step();
    checks++; if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b1) begin errors++; $display("FAIL wr_access: got psel=%b penable=%b want 1 1", apb.PSEL, apb.PENABLE); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_access_rsp: got %b want 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_resp: got valid=%b psel=%b penable=%b want 1 0 0", rsp_valid, apb.PSEL, apb.PENABLE); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp_data: got err=%b to=%b rdata=%h want 0 0 0", rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_done: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_read_wait();
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 32'h10, 32'h1234_5678);
    checks++; if (apb.PWRITE !== 1'b0 || apb.PWDATA !== 32'h0) begin errors++; $display("FAIL rd_setup_bus: got pwrite=%b pwdata=%h want 0 0", apb.PWRITE, apb.PWDATA); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b1 || apb.PADDR !== 32'h10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access_%0d: got psel=%b pen=%b paddr=%h valid=%b want 1 1 00000010 0", i, apb.PSEL, apb.PENABLE, apb.PADDR, rsp_valid); end
      if (i == 3) apb.PREADY = 1'b1;
      step();
    end
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got valid=%b rdata=%h err=%b want 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slave_err();
    apb.PREADY = 1'b1;
    apb.PSLVERR = 1'b1;
    apb.PRDATA = 32'hA5A5_A5A5;
    issue(1'b0, 32'd200, 32'h0);
    step();
    step();
    apb.PSLVERR = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL slverr_flags: got valid=%b err=%b to=%b want 1 1 0", rsp_valid, rsp_err, rsp_timeout); end
    checks++; if (rsp_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL slverr_rdata: got %h want a5a5a5a5", rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    // PSLVERR while PREADY is low must not stick
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b1;
    apb.PRDATA = 32'h0000_0042;
    issue(1'b0, 32'h24, 32'h0);
    step();
    apb.PREADY = 1'b1;
    apb.PSLVERR = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h42) begin errors++; $display("FAIL slverr_ignored: got valid=%b err=%b rdata=%h want 1 0 00000042", rsp_valid, rsp_err, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int acc;
    acc = 0;
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 32'h20, 32'h0);
    step();
    for (int i = 0; i < 40; i++) begin
      if (apb.PENABLE !== 1'b1) break;
      acc++;
      step();
    end
    checks++; if (acc !== 16) begin errors++; $display("FAIL to_access_cycles: got %0d want 16", acc); end
    checks++; if (apb.PSEL !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL to_resp: got psel=%b valid=%b want 0 1", apb.PSEL, rsp_valid); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_flags: got err=%b to=%b rdata=%h want 1 1 0", rsp_err, rsp_timeout, rsp_rdata); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    apb.PREADY = 1'b1;
    apb.PSLVERR = 1'b0;
    apb.PRDATA = 32'h0BAD_F00D;
    issue(1'b0, 32'h44, 32'h0);
    step();
    step();
    apb.PRDATA = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0 || req_ready !== 1'b0 || apb.PSEL !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b rready=%b psel=%b want 1 0badf00d 0 0 0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, apb.PSEL); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b rready=%b want 0 1", rsp_valid, req_ready); end
    // rsp_ready with no response pending does nothing
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || apb.PSEL !== 1'b0) begin errors++; $display("FAIL idle_rsp_ready: got valid=%b rready=%b psel=%b want 0 1 0", rsp_valid, req_ready, apb.PSEL); end
    apb.PREADY = 1'b0;
    issue(1'b1, 32'h48, 32'hCAFE_0001);
    step();
    checks++; if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b1) begin errors++; $display("FAIL rst2_access: got psel=%b pen=%b want 1 1", apb.PSEL, apb.PENABLE); end
    #2;
    PRESETN = 1'b0;
    #1;
    checks++; if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst2_async: got psel=%b pen=%b valid=%b want 0 0 0", apb.PSEL, apb.PENABLE, rsp_valid); end
    step();
    PRESETN = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || apb.PSEL !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst2_idle: got rready=%b psel=%b valid=%b want 1 0 0", req_ready, apb.PSEL, rsp_valid); end
  endtask

  initial begin
    PRESETN     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    rsp_ready   = 1'b0;
    apb.PRDATA  = 32'h0;
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_err();
    test_timeout();
    test_backpressure_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, got stuck want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
